pipelined_adder: RTL

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/adder_pkg.sv | 20 ++
 rtl/rca_slice.sv | 29 ++
 rtl/pipelined_adder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// ============================================================================
// Module   : adder_pkg
// Purpose  : Shared mode encodings and default geometry for pipelined_adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_STAGES = 2;

endpackage

`default_nettype wire

// File: rtl/rca_slice.sv
// ============================================================================
// Module   : rca_slice
// Purpose  : Combinational N-bit adder slice with carry into its top bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rca_slice #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         c_msb_in
);

  logic [N:0] w_full;

  assign w_full   = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
  assign s        = w_full[N-1:0];
  assign cout     = w_full[N];
  // The sum bit is a^b^carry-in, so the carry into the MSB falls out directly.
  assign c_msb_in = s[N-1] ^ a[N-1] ^ b[N-1];

endmodule

`default_nettype wire

// File: rtl/pipelined_adder.sv
// ============================================================================
// Module   : pipelined_adder
// Purpose  : Valid/ready add/subtract pipeline, one SLICE-bit adder per stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SLICE = WIDTH / STAGES;

  logic w_en;

  assign w_en     = !(out_valid && !out_ready);
  assign in_ready = w_en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO      = k * SLICE;
    localparam int REM_IN  = WIDTH - LO;
    localparam int DONE    = LO + SLICE;

    logic [REM_IN-1:0] w_a_in;
    logic [REM_IN-1:0] w_b_in;
    logic              w_c_in;
    logic              w_v_in;
    logic [SLICE-1:0]  w_slice_s;
    logic              w_cout;
    logic [DONE-1:0]   w_s_nxt;
    logic [DONE-1:0]   r_s;
    logic              r_c;
    logic              r_v;

    if (k == 0) begin : g_head
      // Subtract is A + ~B + 1: invert B here and force the carry-in.
      assign w_a_in  = a;
      assign w_b_in  = (mode == MODE_SUB) ? ~b : b;
      assign w_c_in  = (mode == MODE_SUB) ? 1'b1 : cin;
      assign w_v_in  = in_valid;
      assign w_s_nxt = w_slice_s;
    end else begin : g_body
      assign w_a_in  = g_stage[k-1].g_fwd.r_a;
      assign w_b_in  = g_stage[k-1].g_fwd.r_b;
      assign w_c_in  = g_stage[k-1].r_c;
      assign w_v_in  = g_stage[k-1].r_v;
      assign w_s_nxt = {w_slice_s, g_stage[k-1].r_s};
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s <= '0;
        r_c <= 1'b0;
        r_v <= 1'b0;
      end else if (w_en) begin
        r_s <= w_s_nxt;
        r_c <= w_cout;
        r_v <= w_v_in;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      localparam int REM_OUT = REM_IN - SLICE;

      logic [REM_OUT-1:0] r_a;
      logic [REM_OUT-1:0] r_b;
      logic               w_cmsb_nc;

      rca_slice #(.N(SLICE)) u_rca (
        .a        (w_a_in[SLICE-1:0]),
        .b        (w_b_in[SLICE-1:0]),
        .cin      (w_c_in),
        .s        (w_slice_s),
        .cout     (w_cout),
        .c_msb_in (w_cmsb_nc)
      );

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_en) begin
          r_a <= w_a_in[REM_IN-1:SLICE];
          r_b <= w_b_in[REM_IN-1:SLICE];
        end
      end
    end else begin : g_tail
      logic w_cmsb;
      logic r_ovf;

      rca_slice #(.N(SLICE)) u_rca (
        .a        (w_a_in),
        .b        (w_b_in),
        .cin      (w_c_in),
        .s        (w_slice_s),
        .cout     (w_cout),
        .c_msb_in (w_cmsb)
      );

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_ovf <= 1'b0;
        end else if (w_en) begin
          r_ovf <= w_cmsb ^ w_cout;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_v;
  assign sum       = g_stage[STAGES-1].r_s;
  assign cout      = g_stage[STAGES-1].r_c;
  assign ovf       = g_stage[STAGES-1].g_tail.r_ovf;

endmodule

`default_nettype wire
